// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control path: FSM state encoding,
// default display widths and the default debounce length.
package stopwatch_pkg;

  // 50 ms of stable level at the 5 MHz board clock
  localparam int DEBOUNCE_CYCLES_DEF = 250000;

  // Seconds and tenths widths coming from the counter
  localparam int SEG_W_DEF = 10;
  localparam int DEC_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_e;

  // The counter is advancing in both RUN and LAP
  function automatic logic is_running(input sw_state_e s);
    return (s == RUN) || (s == LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Bundle of the signals between the stopwatch controller and its
// surroundings: raw buttons, live counter value, counter control and
// display / status outputs. The slave side is the controller itself.
interface stopwatch_ctrl_if
  import stopwatch_pkg::*;
#(
  parameter int SEG_W = SEG_W_DEF,
  parameter int DEC_W = DEC_W_DEF
) ();

  logic             btn_start_stop;
  logic             btn_lap_clear;
  logic [SEG_W-1:0] cont_seg;
  logic [DEC_W-1:0] cont_dec;
  logic             count_en;
  logic             count_clr;
  logic [SEG_W-1:0] disp_seg;
  logic [DEC_W-1:0] disp_dec;
  logic             running;
  logic             lap_active;

  // Board / counter side: drives buttons and live count, observes control
  modport master (
    output btn_start_stop, btn_lap_clear, cont_seg, cont_dec,
    input  count_en, count_clr, disp_seg, disp_dec, running, lap_active
  );

  // Controller side
  modport slave (
    input  btn_start_stop, btn_lap_clear, cont_seg, cont_dec,
    output count_en, count_clr, disp_seg, disp_dec, running, lap_active
  );

endinterface

// File: rtl/stopwatch_ctrl_debounce.sv
// Front-panel button conditioning: 2-FF synchronizer, stable-level
// debouncer and a one-cycle pulse on each accepted press (release gives
// no pulse). A held button therefore yields exactly one pulse.
module button_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press_p
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync_ff1;
  logic             sync_ff2;
  logic             level_q;
  logic             level_dly;
  logic             press_q;
  logic [CNT_W-1:0] stable_cnt;

  // Bring the asynchronous button into the clk domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_ff1 <= 1'b0;
      sync_ff2 <= 1'b0;
    end else begin
      sync_ff1 <= btn_raw;
      sync_ff2 <= sync_ff1;
    end
  end

  // Accept a new level only after it has differed for the full count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q    <= 1'b0;
      stable_cnt <= '0;
    end else if (sync_ff2 != level_q) begin
      if (stable_cnt == CNT_MAX) begin
        level_q    <= ~level_q;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
    end else begin
      stable_cnt <= '0;
    end
  end

  // Registered rising-edge detect on the accepted level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_dly <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      level_dly <= level_q;
      press_q   <= level_q & ~level_dly;
    end
  end

  assign press_p = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: debounces start/stop and lap/clear, runs
// the IDLE/RUN/PAUSE/LAP machine, drives counter enable/clear and picks
// either the live count (one register stage behind) or the frozen lap
// snapshot for the display.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SEG_W           = SEG_W_DEF,
  parameter int DEC_W           = DEC_W_DEF
) (
  input logic             clk,
  input logic             reset,
  stopwatch_ctrl_if.slave bus
);

  logic             ss_p;
  logic             lc_p;
  sw_state_e        state_q;
  sw_state_e        state_d;
  logic             snap_load;
  logic [SEG_W-1:0] snap_seg;
  logic [DEC_W-1:0] snap_dec;
  logic [SEG_W-1:0] live_seg;
  logic [DEC_W-1:0] live_dec;
  logic             count_en;
  logic             count_clr;
  logic             lap_active;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_start_stop (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (bus.btn_start_stop),
    .press_p (ss_p)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_lap_clear (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (bus.btn_lap_clear),
    .press_p (lc_p)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; start/stop has priority and a coincident lap press is dropped
  always_comb begin
    state_d   = state_q;
    snap_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_p) state_d = RUN;
      end
      RUN: begin
        if (ss_p) begin
          state_d = PAUSE;
        end else if (lc_p) begin
          state_d   = LAP;
          snap_load = 1'b1;
        end
      end
      LAP: begin
        if (ss_p) state_d = PAUSE;
        else if (lc_p) state_d = RUN;
      end
      PAUSE: begin
        if (ss_p) state_d = RUN;
        else if (lc_p) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore decode of counter control and lap indicator
  always_comb begin
    count_en   = 1'b0;
    count_clr  = 1'b0;
    lap_active = 1'b0;
    case (state_q)
      IDLE:    count_clr = 1'b1;
      RUN:     count_en  = 1'b1;
      LAP: begin
        count_en   = 1'b1;
        lap_active = 1'b1;
      end
      PAUSE:   count_en  = 1'b0;
      default: count_clr = 1'b1;
    endcase
  end

  // Capture the live count on the RUN to LAP transition, hold otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_seg <= '0;
      snap_dec <= '0;
    end else if (snap_load) begin
      snap_seg <= bus.cont_seg;
      snap_dec <= bus.cont_dec;
    end
  end

  // One register stage on the live count feeding the display
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live_seg <= '0;
      live_dec <= '0;
    end else begin
      live_seg <= bus.cont_seg;
      live_dec <= bus.cont_dec;
    end
  end

  assign bus.count_en   = count_en;
  assign bus.count_clr  = count_clr;
  assign bus.lap_active = lap_active;
  assign bus.running    = is_running(state_q);
  assign bus.disp_seg   = (state_q == LAP) ? snap_seg : live_seg;
  assign bus.disp_dec   = (state_q == LAP) ? snap_dec : live_dec;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a short debounce window.
module tb_stopwatch_ctrl;

  localparam int DB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   saw_lap = 1'b0;

  stopwatch_ctrl_if #(.SEG_W(10), .DEC_W(4)) sw_if ();

  stopwatch_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .SEG_W(10),
    .DEC_W(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sw_if)
  );

  always #5 clk = ~clk;

  // Advance one clock and sample just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (sw_if.lap_active) saw_lap = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Hold the given buttons, release, then wait out the release debounce
  task automatic applyStimulus(input logic ss, input logic lc, input int hold);
    sw_if.btn_start_stop = ss;
    sw_if.btn_lap_clear  = lc;
    repeat (hold) tick();
    sw_if.btn_start_stop = 1'b0;
    sw_if.btn_lap_clear  = 1'b0;
    repeat (12) tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  lat;
    int  rises;
    bit  any_en;
    bit  prev_run;

    sw_if.btn_start_stop = 1'b0;
    sw_if.btn_lap_clear  = 1'b0;
    sw_if.cont_seg       = '0;
    sw_if.cont_dec       = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) tick();

    checkOutput("rst_count_clr", 32'(sw_if.count_clr), 1);
    checkOutput("rst_count_en", 32'(sw_if.count_en), 0);
    checkOutput("rst_disp_seg", 32'(sw_if.disp_seg), 0);
    checkOutput("rst_disp_dec", 32'(sw_if.disp_dec), 0);
    checkOutput("rst_running", 32'(sw_if.running), 0);
    checkOutput("rst_lap_active", 32'(sw_if.lap_active), 0);

    // Start press: latency from first high sample to count_en
    sw_if.btn_start_stop = 1'b1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 10) sw_if.btn_start_stop = 1'b0;
      if (sw_if.count_en && lat < 0) lat = i - 1;
    end
    repeat (5) tick();
    checkOutput("start_latency", 32'(lat), 8);
    checkOutput("run_count_en", 32'(sw_if.count_en), 1);
    checkOutput("run_count_clr", 32'(sw_if.count_clr), 0);
    checkOutput("run_running", 32'(sw_if.running), 1);
    checkOutput("run_lap_active", 32'(sw_if.lap_active), 0);

    // Live display lags the counter by one cycle
    sw_if.cont_seg = 10'd5;
    sw_if.cont_dec = 4'd1;
    tick();
    sw_if.cont_seg = 10'd6;
    sw_if.cont_dec = 4'd2;
    checkOutput("lag_seg_a", 32'(sw_if.disp_seg), 5);
    checkOutput("lag_dec_a", 32'(sw_if.disp_dec), 1);
    tick();
    checkOutput("lag_seg_b", 32'(sw_if.disp_seg), 6);
    checkOutput("lag_dec_b", 32'(sw_if.disp_dec), 2);

    applyStimulus(1'b1, 1'b0, 10);
    checkOutput("pause_count_en", 32'(sw_if.count_en), 0);
    checkOutput("pause_count_clr", 32'(sw_if.count_clr), 0);
    checkOutput("pause_running", 32'(sw_if.running), 0);

    applyStimulus(1'b1, 1'b0, 10);
    checkOutput("resume_count_en", 32'(sw_if.count_en), 1);

    applyStimulus(1'b1, 1'b0, 10);
    checkOutput("pause2_count_en", 32'(sw_if.count_en), 0);
    applyStimulus(1'b0, 1'b1, 10);
    checkOutput("clear_count_clr", 32'(sw_if.count_clr), 1);
    checkOutput("clear_count_en", 32'(sw_if.count_en), 0);

    // Bouncing start/stop, never stable long enough
    any_en = 1'b0;
    for (int i = 0; i < 30; i++) begin
      sw_if.btn_start_stop = ((i % 4) < 2);
      tick();
      if (sw_if.count_en) any_en = 1'b1;
    end
    sw_if.btn_start_stop = 1'b0;
    repeat (12) begin
      tick();
      if (sw_if.count_en) any_en = 1'b1;
    end
    checkOutput("bounce_no_en", 32'(any_en), 0);
    checkOutput("bounce_count_clr", 32'(sw_if.count_clr), 1);
    checkOutput("bounce_running", 32'(sw_if.running), 0);

    // Lap snapshot at 37/4
    sw_if.cont_seg = 10'd37;
    sw_if.cont_dec = 4'd4;
    applyStimulus(1'b1, 1'b0, 10);
    applyStimulus(1'b0, 1'b1, 10);
    checkOutput("lap_active", 32'(sw_if.lap_active), 1);
    sw_if.cont_seg = 10'd38;
    sw_if.cont_dec = 4'd9;
    tick();
    sw_if.cont_seg = 10'd40;
    sw_if.cont_dec = 4'd0;
    tick();
    tick();
    checkOutput("lap_disp_seg", 32'(sw_if.disp_seg), 37);
    checkOutput("lap_disp_dec", 32'(sw_if.disp_dec), 4);
    checkOutput("lap_count_en", 32'(sw_if.count_en), 1);
    checkOutput("lap_running", 32'(sw_if.running), 1);

    applyStimulus(1'b0, 1'b1, 10);
    checkOutput("unlap_lap_active", 32'(sw_if.lap_active), 0);
    checkOutput("unlap_disp_seg", 32'(sw_if.disp_seg), 40);
    checkOutput("unlap_disp_dec", 32'(sw_if.disp_dec), 0);
    sw_if.cont_seg = 10'd41;
    sw_if.cont_dec = 4'd5;
    checkOutput("unlap_lag_hold", 32'(sw_if.disp_seg), 40);
    tick();
    checkOutput("unlap_lag_seg", 32'(sw_if.disp_seg), 41);
    checkOutput("unlap_lag_dec", 32'(sw_if.disp_dec), 5);

    // Both buttons together in RUN: start/stop wins
    sw_if.cont_seg = 10'd50;
    sw_if.cont_dec = 4'd7;
    saw_lap = 1'b0;
    applyStimulus(1'b1, 1'b1, 10);
    checkOutput("simul_no_lap", 32'(saw_lap), 0);
    checkOutput("simul_count_en", 32'(sw_if.count_en), 0);
    checkOutput("simul_running", 32'(sw_if.running), 0);
    checkOutput("simul_disp_seg", 32'(sw_if.disp_seg), 50);
    checkOutput("simul_disp_dec", 32'(sw_if.disp_dec), 7);

    // Back to LAP, then reset between clock edges
    applyStimulus(1'b1, 1'b0, 10);
    sw_if.cont_seg = 10'd60;
    sw_if.cont_dec = 4'd2;
    applyStimulus(1'b0, 1'b1, 10);
    checkOutput("lap2_active", 32'(sw_if.lap_active), 1);
    checkOutput("lap2_disp_seg", 32'(sw_if.disp_seg), 60);
    #3 reset = 1'b1;
    #1;
    checkOutput("arst_count_clr", 32'(sw_if.count_clr), 1);
    checkOutput("arst_count_en", 32'(sw_if.count_en), 0);
    checkOutput("arst_running", 32'(sw_if.running), 0);
    checkOutput("arst_lap_active", 32'(sw_if.lap_active), 0);
    checkOutput("arst_disp_seg", 32'(sw_if.disp_seg), 0);
    checkOutput("arst_disp_dec", 32'(sw_if.disp_dec), 0);

    // Button held through reset release gives one press
    sw_if.btn_start_stop = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    lat = -1;
    rises = 0;
    prev_run = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 25) sw_if.btn_start_stop = 1'b0;
      if (sw_if.count_en && lat < 0) lat = i - 1;
      if (sw_if.running && !prev_run) rises++;
      prev_run = sw_if.running;
    end
    repeat (12) begin
      tick();
      if (sw_if.running && !prev_run) rises++;
      prev_run = sw_if.running;
    end
    checkOutput("held_latency", 32'(lat), 8);
    checkOutput("held_one_press", 32'(rises), 1);
    checkOutput("held_running", 32'(sw_if.running), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control sequencer for the stopwatch counter. It debounces the two front-panel push-buttons and runs a start/pause/lap/clear state machine. It drives the counter's enable and clear inputs and selects what reaches the 7-segment display: live count or a frozen lap snapshot. It sits between the raw board buttons and the counter/display path, in the same 5 MHz clock domain.

## Interface
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles required before a button level is accepted (50 ms at 5 MHz).
- SEG_W, 10: width of the seconds count.
- DEC_W, 4: width of the tenths count.
- Clock and reset: one clock; reset is asynchronous and active-high. Ports are named clk and reset.
- clk  in  1  system clock, 5 MHz.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- btn_start_stop  in  1  raw button, active-high, asynchronous to clk.
- btn_lap_clear  in  1  raw button, active-high, asynchronous to clk.
- cont_seg  in  SEG_W  live seconds from the counter.
- cont_dec  in  DEC_W  live tenths from the counter.
- count_en  out  1  counter advances only while high.
- count_clr  out  1  synchronous clear request to the counter.
- disp_seg  out  SEG_W  seconds value to display.
- disp_dec  out  DEC_W  tenths value to display.
- running  out  1  status LED: state is RUN or LAP.
- lap_active  out  1  status LED: display is frozen.

## Operation
- Each button passes through a 2-FF synchronizer, then a debouncer.
  - The debouncer counts consecutive cycles in which the synchronized level differs from the accepted level.
  - When the count reaches DEBOUNCE_CYCLES, the accepted level flips and the count resets.
  - Any cycle with the synchronized level equal to the accepted level resets the count.
  - A rising edge of the accepted level produces a single-cycle press pulse: ss_p for start/stop, lc_p for lap/clear. Releases produce no pulse.
- FSM states: IDLE, RUN, PAUSE, LAP.
  - IDLE: ss_p -> RUN; lc_p ignored.
  - RUN: ss_p -> PAUSE; lc_p -> LAP, capturing the snapshot.
  - LAP: ss_p -> PAUSE; lc_p -> RUN, releasing the freeze.
  - PAUSE: ss_p -> RUN; lc_p -> IDLE.
- Simultaneous ss_p and lc_p in the same cycle: ss_p wins and lc_p is discarded (not queued).
- Moore outputs, decoded from the state register:
  - IDLE: count_clr=1, count_en=0.
  - RUN: count_clr=0, count_en=1.
  - LAP: count_clr=0, count_en=1.
  - PAUSE: count_clr=0, count_en=0.
  - running=1 in RUN and LAP; lap_active=1 in LAP only.
- Snapshot registers (SEG_W+DEC_W bits) load cont_seg/cont_dec in the cycle the FSM takes RUN->LAP. They hold otherwise.
- Display select:
  - LAP: disp_seg/disp_dec = snapshot.
  - All other states: disp_seg/disp_dec = cont_seg/cont_dec, registered by one stage.
  - LAP->PAUSE: the display switches to live. Counting stopped on that transition, so the live value is the final time.
- The counter keeps counting during LAP. Wrap-around of the counter values is passed through unchanged; this block does no arithmetic on them.

## Timing
- Reset values: state=IDLE, count_clr=1, count_en=0, disp_seg=0, disp_dec=0, running=0, lap_active=0, snapshot=0, debounce counters=0, accepted levels=0.
- Press latency: a raw high held steady produces ss_p/lc_p exactly DEBOUNCE_CYCLES+3 clk edges after the first clk edge that samples it high (2 sync + DEBOUNCE_CYCLES + 1 edge detect).
- State and Moore outputs update on the edge after the pulse.
- disp_* lag cont_* by 1 cycle when live.
- A glitch shorter than DEBOUNCE_CYCLES consecutive cycles produces no pulse.
- A held button produces exactly one pulse; a new pulse requires a debounced release first.
- reset asserted mid-operation returns all outputs to reset values asynchronously. After deassertion, the FSM resumes from IDLE. A button held through reset deassertion yields one pulse after the debounce time.

## Structure
- Shared package stopwatch_pkg holds:
  - the state enum (IDLE/RUN/PAUSE/LAP, 2-bit encoding);
  - SEG_W/DEC_W defaults;
  - the default DEBOUNCE_CYCLES constant.
- One sub-module, button_debounce (synchronizer + debouncer + rising-edge pulse), instantiated twice.
- The FSM, snapshot and display mux stay in stopwatch_ctrl.

## Test plan
- Use DEBOUNCE_CYCLES=4 throughout.
- Reset then idle 20 cycles -> count_clr=1, count_en=0, disp=0/0, running=0.
- Start/pause/resume/clear: btn_start_stop high 10 cycles -> count_en rises exactly 8 cycles after the first high sample. Press again -> PAUSE, count_en=0. Press again -> RUN. Press btn_lap_clear in PAUSE -> IDLE, count_clr=1.
- Bounce: btn_start_stop toggling every 2 cycles for 30 cycles, then low -> no state change, count_en stays 0.
- Lap: in RUN with cont_seg=37, cont_dec=4 at the transition cycle, press lap -> disp holds 37/4 while cont_* advance to 40/0; lap_active=1. Press lap again -> disp tracks cont_* with 1-cycle lag.
- Simultaneous: both buttons pressed in RUN with identical timing -> state PAUSE, no LAP entry, snapshot unchanged.
- Mid-operation reset: assert reset asynchronously in LAP between clock edges -> outputs at reset values before the next edge. Release with btn_start_stop held -> exactly one ss_p, then RUN.
